voice_alloc: RTL and testbench

Polyphonic voice allocator that shares a fixed bank of oscillator voices (one tri/saw oscillator per voice) between incoming note events. It accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a free voice. With stealing compiled in, it reclaims the oldest voice when the bank is full. It sits between the note/key decoder and the oscillator bank and drives each oscillator's 12-bit `freq` input plus a per-voice active flag for the mixer.

---
 rtl/voice_alloc_pkg.sv | 15 +
 rtl/voice_alloc_if.sv | 25 ++
 rtl/voice_age_bank.sv | 33 +++
 rtl/voice_alloc.sv | 169 ++++++++++++++++
 tb/tb_voice_alloc.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator.
package voice_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int FREQ_W       = 12;
  localparam int AGE_W        = 8;
  localparam int DEFAULT_FREQ = 440;
  localparam int AGE_MAX      = 255;

endpackage

// File: rtl/voice_alloc_if.sv
// Note-event handshake plus per-voice oscillator/mixer outputs.
// master = note decoder side, slave = allocator.
interface voice_alloc_if #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = voice_alloc_pkg::FREQ_W
);
  logic                         ev_valid;
  logic                         ev_ready;
  logic                         ev_on;
  logic [FREQ_W-1:0]            ev_freq;
  logic [NUM_VOICES*FREQ_W-1:0] voice_freq;
  logic [NUM_VOICES-1:0]        voice_active;
  logic                         steal_pulse;
  logic                         drop_pulse;

  modport master (
    output ev_valid, ev_on, ev_freq,
    input  ev_ready, voice_freq, voice_active, steal_pulse, drop_pulse
  );

  modport slave (
    input  ev_valid, ev_on, ev_freq,
    output ev_ready, voice_freq, voice_active, steal_pulse, drop_pulse
  );
endinterface

// File: rtl/voice_age_bank.sv
// Saturating per-voice age counters; on i_inc the cleared voice goes to 0 and
// every other active voice ages by one. Single-cycle update, no backpressure.
module voice_age_bank
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_inc,
  input  logic [IDX_W-1:0]                 i_clr_idx,
  input  logic [NUM_VOICES-1:0]            i_active,
  output logic [NUM_VOICES-1:0][AGE_W-1:0] o_age
);
  logic [NUM_VOICES-1:0][AGE_W-1:0] r_age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (i_inc) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == i_clr_idx) begin
          r_age[i] <= '0;
        end else if (i_active[i] && (r_age[i] != AGE_W'(AGE_MAX))) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  assign o_age = r_age;
endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: one event per NUM_VOICES+2 cycles, ev_ready low while scanning/committing.
// VOICE_ALLOC_STEAL_EN: full-bank note-on steals the oldest voice instead of being dropped.
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = voice_alloc_pkg::FREQ_W
) (
  input logic          clk,
  input logic          rst_n,
  voice_alloc_if.slave bus
);
  import voice_alloc_pkg::*;

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t                            r_state, w_state_nxt;
  logic                              r_ready;
  logic                              r_on;
  logic [FREQ_W-1:0]                 r_freq;
  logic [IDX_W-1:0]                  r_idx;
  logic                              r_match_vld, r_free_vld;
  logic [IDX_W-1:0]                  r_match_idx, r_free_idx;
  logic [NUM_VOICES-1:0][FREQ_W-1:0] r_freq_bank;
  logic [NUM_VOICES-1:0]             r_active;
  logic                              r_drop;
  logic                              w_hs, w_commit, w_new_on;
  logic                              w_retrig, w_alloc, w_full, w_release, w_steal, w_drop;
  logic [IDX_W-1:0]                  w_tgt_idx;
  logic                              w_cur_act;
  logic [FREQ_W-1:0]                 w_cur_freq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = SEARCH;
      SEARCH:  if (r_idx == LAST_IDX) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hs       = (r_state == IDLE) && r_ready && bus.ev_valid;
  assign w_commit   = (r_state == COMMIT);
  assign w_cur_act  = r_active[r_idx];
  assign w_cur_freq = r_freq_bank[r_idx];

  // A zero frequency would stall the oscillator divider, so it never reaches a lane.
  assign w_new_on  = w_commit && r_on && (r_freq != '0);
  assign w_retrig  = w_new_on && r_match_vld;
  assign w_alloc   = w_new_on && !r_match_vld && r_free_vld;
  assign w_full    = w_new_on && !r_match_vld && !r_free_vld;
  assign w_release = w_commit && !r_on && r_match_vld;

`ifdef VOICE_ALLOC_STEAL_EN
  logic                             r_old_vld;
  logic [IDX_W-1:0]                 r_old_idx;
  logic [AGE_W-1:0]                 r_old_age;
  logic                             r_steal;
  logic [NUM_VOICES-1:0][AGE_W-1:0] w_ages;

  assign w_steal = w_full;
  assign w_drop  = w_commit && r_on && (r_freq == '0);

  voice_age_bank #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W)) u_age_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_retrig || w_alloc || w_steal),
    .i_clr_idx (w_tgt_idx),
    .i_active  (r_active),
    .o_age     (w_ages)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_old_vld <= 1'b0;
      r_old_idx <= '0;
      r_old_age <= '0;
      r_steal   <= 1'b0;
    end else begin
      r_steal <= w_steal;
      if (w_hs) begin
        r_old_vld <= 1'b0;
      end else if ((r_state == SEARCH) && w_cur_act &&
                   (!r_old_vld || (w_ages[r_idx] > r_old_age))) begin
        r_old_vld <= 1'b1;
        r_old_idx <= r_idx;
        r_old_age <= w_ages[r_idx];
      end
    end
  end

  assign bus.steal_pulse = r_steal;
`else
  assign w_steal = 1'b0;
  assign w_drop  = w_commit && r_on && ((r_freq == '0) || w_full);
  assign bus.steal_pulse = 1'b0;
`endif

  always_comb begin
    w_tgt_idx = r_free_idx;
    if (r_match_vld) begin
      w_tgt_idx = r_match_idx;
    end
`ifdef VOICE_ALLOC_STEAL_EN
    else if (!r_free_vld) begin
      w_tgt_idx = r_old_idx;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on        <= 1'b0;
      r_freq      <= '0;
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_active    <= '0;
      r_drop      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_freq_bank[i] <= FREQ_W'(DEFAULT_FREQ);
      end
    end else begin
      r_drop <= w_drop;
      if (w_hs) begin
        r_on        <= bus.ev_on;
        r_freq      <= bus.ev_freq;
        r_idx       <= '0;
        r_match_vld <= 1'b0;
        r_free_vld  <= 1'b0;
      end else if (r_state == SEARCH) begin
        r_idx <= r_idx + 1'b1;
        if (w_cur_act && (w_cur_freq == r_freq) && !r_match_vld) begin
          r_match_vld <= 1'b1;
          r_match_idx <= r_idx;
        end
        if (!w_cur_act && !r_free_vld) begin
          r_free_vld <= 1'b1;
          r_free_idx <= r_idx;
        end
      end
      if (w_alloc || w_steal) begin
        r_freq_bank[w_tgt_idx] <= r_freq;
        r_active[w_tgt_idx]    <= 1'b1;
      end
      // Released voices keep their frequency so the oscillator sees no step.
      if (w_release) begin
        r_active[w_tgt_idx] <= 1'b0;
      end
    end
  end

  assign bus.ev_ready     = r_ready;
  assign bus.voice_freq   = r_freq_bank;
  assign bus.voice_active = r_active;
  assign bus.drop_pulse   = r_drop;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc with NUM_VOICES = 4; expectations follow VOICE_ALLOC_STEAL_EN.
module tb_voice_alloc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  voice_alloc_if #(.NUM_VOICES(4), .FREQ_W(12)) bus ();

  voice_alloc #(.NUM_VOICES(4), .FREQ_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lane(input int i);
    return bus.voice_freq[i*12 +: 12];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_on = 1'b0;
    bus.ev_freq = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Sends one event; reports ready-low cycles and pulses at the first ready cycle and the one after.
  task automatic ev(input logic on, input logic [11:0] f, output int low,
                    output logic st, output logic dr, output logic st2, output logic dr2);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ev_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ev_ready_wait: ev_ready stuck at %b, want 1", bus.ev_ready);
    end
    bus.ev_valid = 1'b1;
    bus.ev_on = on;
    bus.ev_freq = f;
    @(posedge clk);
    #1;
    bus.ev_valid = 1'b0;
    bus.ev_on = ~on;
    bus.ev_freq = 12'hABC;
    low = 0;
    @(negedge clk);
    while (bus.ev_ready === 1'b0 && low < 50) begin
      low++;
      @(negedge clk);
    end
    st = bus.steal_pulse;
    dr = bus.drop_pulse;
    @(negedge clk);
    st2 = bus.steal_pulse;
    dr2 = bus.drop_pulse;
  endtask

  task automatic fill4();
    int l;
    logic a, b, c, d;
    ev(1'b1, 12'd100, l, a, b, c, d);
    ev(1'b1, 12'd200, l, a, b, c, d);
    ev(1'b1, 12'd300, l, a, b, c, d);
    ev(1'b1, 12'd400, l, a, b, c, d);
  endtask

  task automatic test_reset();
    int l;
    logic a, b, c, d;
    do_reset();
    ev(1'b1, 12'd123, l, a, b, c, d);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.voice_active !== 4'b0000) begin n_fail++; $display("FAIL reset_active: got %b want 0000", bus.voice_active); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (lane(i) !== 12'd440) begin n_fail++; $display("FAIL reset_lane%0d: got %0d want 440", i, lane(i)); end
    end
    n_checks++; if (bus.ev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ev_ready); end
    n_checks++; if (bus.steal_pulse !== 1'b0 || bus.drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got steal=%b drop=%b want 0 0", bus.steal_pulse, bus.drop_pulse); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_notes();
    int l0, l1;
    logic a, b, c, d;
    logic [11:0] e[4];
    do_reset();
    ev(1'b1, 12'd262, l0, a, b, c, d);
    ev(1'b1, 12'd330, l1, a, b, c, d);
    e = '{12'd262, 12'd330, 12'd440, 12'd440};
    n_checks++; if (l0 !== 5) begin n_fail++; $display("FAIL two_notes_busy0: got %0d cycles want 5", l0); end
    n_checks++; if (l1 !== 5) begin n_fail++; $display("FAIL two_notes_busy1: got %0d cycles want 5", l1); end
    n_checks++; if (bus.voice_active !== 4'b0011) begin n_fail++; $display("FAIL two_notes_active: got %b want 0011", bus.voice_active); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (lane(i) !== e[i]) begin n_fail++; $display("FAIL two_notes_lane%0d: got %0d want %0d", i, lane(i), e[i]); end
    end
    n_checks++; if (a !== 1'b0 || b !== 1'b0) begin n_fail++; $display("FAIL two_notes_pulses: got steal=%b drop=%b want 0 0", a, b); end
  endtask

  task automatic test_full_bank();
    int l;
    logic st, dr, st2, dr2;
    logic [11:0] e[4];
    do_reset();
    fill4();
    n_checks++; if (bus.voice_active !== 4'b1111) begin n_fail++; $display("FAIL full_active_before: got %b want 1111", bus.voice_active); end
    ev(1'b1, 12'd500, l, st, dr, st2, dr2);
`ifdef VOICE_ALLOC_STEAL_EN
    e = '{12'd500, 12'd200, 12'd300, 12'd400};
    n_checks++; if (st !== 1'b1 || st2 !== 1'b0) begin n_fail++; $display("FAIL full_steal_pulse: got %b,%b want 1,0", st, st2); end
    n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL full_no_drop: got %b want 0", dr); end
`else
    e = '{12'd100, 12'd200, 12'd300, 12'd400};
    n_checks++; if (dr !== 1'b1 || dr2 !== 1'b0) begin n_fail++; $display("FAIL full_drop_pulse: got %b,%b want 1,0", dr, dr2); end
    n_checks++; if (st !== 1'b0) begin n_fail++; $display("FAIL full_no_steal: got %b want 0", st); end
`endif
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (lane(i) !== e[i]) begin n_fail++; $display("FAIL full_lane%0d: got %0d want %0d", i, lane(i), e[i]); end
    end
    n_checks++; if (bus.voice_active !== 4'b1111) begin n_fail++; $display("FAIL full_active_after: got %b want 1111", bus.voice_active); end
  endtask

  task automatic test_release_reuse();
    int l;
    logic st, dr, st2, dr2;
    do_reset();
    fill4();
    ev(1'b0, 12'd300, l, st, dr, st2, dr2);
    n_checks++; if (bus.voice_active !== 4'b1011) begin n_fail++; $display("FAIL release_active: got %b want 1011", bus.voice_active); end
    n_checks++; if (lane(2) !== 12'd300) begin n_fail++; $display("FAIL release_hold: got %0d want 300", lane(2)); end
    n_checks++; if (st !== 1'b0 || dr !== 1'b0) begin n_fail++; $display("FAIL release_pulses: got steal=%b drop=%b want 0 0", st, dr); end
    ev(1'b0, 12'd999, l, st, dr, st2, dr2);
    n_checks++; if (bus.voice_active !== 4'b1011 || st !== 1'b0 || dr !== 1'b0) begin n_fail++; $display("FAIL off_nomatch: got active=%b steal=%b drop=%b want 1011 0 0", bus.voice_active, st, dr); end
    ev(1'b1, 12'd600, l, st, dr, st2, dr2);
    n_checks++; if (lane(2) !== 12'd600) begin n_fail++; $display("FAIL reuse_lane2: got %0d want 600", lane(2)); end
    n_checks++; if (bus.voice_active !== 4'b1111) begin n_fail++; $display("FAIL reuse_active: got %b want 1111", bus.voice_active); end
  endtask

  task automatic test_retrigger_zero();
    int l;
    logic st, dr, st2, dr2;
    logic [11:0] e[4];
    do_reset();
    ev(1'b1, 12'd0, l, st, dr, st2, dr2);
    n_checks++; if (dr !== 1'b1 || dr2 !== 1'b0) begin n_fail++; $display("FAIL zero_drop: got %b,%b want 1,0", dr, dr2); end
    n_checks++; if (bus.voice_active !== 4'b0000 || lane(0) !== 12'd440) begin n_fail++; $display("FAIL zero_nochange: got active=%b lane0=%0d want 0000 440", bus.voice_active, lane(0)); end
    fill4();
    ev(1'b1, 12'd100, l, st, dr, st2, dr2);
    n_checks++; if (st !== 1'b0 || dr !== 1'b0 || bus.voice_active !== 4'b1111) begin n_fail++; $display("FAIL retrig100: got steal=%b drop=%b active=%b want 0 0 1111", st, dr, bus.voice_active); end
    ev(1'b1, 12'd200, l, st, dr, st2, dr2);
    n_checks++; if (lane(1) !== 12'd200 || st !== 1'b0 || dr !== 1'b0) begin n_fail++; $display("FAIL retrig200: got lane1=%0d steal=%b drop=%b want 200 0 0", lane(1), st, dr); end
    // Ages are now v0=1 v1=0 v2=3 v3=2, so voice2 is the victim.
    ev(1'b1, 12'd500, l, st, dr, st2, dr2);
`ifdef VOICE_ALLOC_STEAL_EN
    e = '{12'd100, 12'd200, 12'd500, 12'd400};
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL victim_steal: got %b want 1", st); end
`else
    e = '{12'd100, 12'd200, 12'd300, 12'd400};
    n_checks++; if (dr !== 1'b1) begin n_fail++; $display("FAIL victim_drop: got %b want 1", dr); end
`endif
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (lane(i) !== e[i]) begin n_fail++; $display("FAIL victim_lane%0d: got %0d want %0d", i, lane(i), e[i]); end
    end
    ev(1'b1, 12'd0, l, st, dr, st2, dr2);
    n_checks++; if (dr !== 1'b1 || st !== 1'b0 || lane(2) !== e[2]) begin n_fail++; $display("FAIL zero_full: got drop=%b steal=%b lane2=%0d want 1 0 %0d", dr, st, lane(2), e[2]); end
  endtask

  task automatic test_abort();
    int l, n;
    logic st, dr, st2, dr2, bad;
    do_reset();
    ev(1'b1, 12'd100, l, st, dr, st2, dr2);
    n = 0;
    while (bus.ev_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.ev_valid = 1'b1;
    bus.ev_on = 1'b1;
    bus.ev_freq = 12'd777;
    @(posedge clk);
    #1 bus.ev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ev_ready !== 1'b1 || bus.voice_active !== 4'b0000) begin n_fail++; $display("FAIL abort_reset: got ready=%b active=%b want 1 0000", bus.ev_ready, bus.voice_active); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.steal_pulse !== 1'b0 || bus.drop_pulse !== 1'b0 || bus.voice_active !== 4'b0000 ||
          bus.ev_ready !== 1'b1 || lane(0) !== 12'd440 || lane(1) !== 12'd440) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL abort_no_commit: got activity=%b want 0 (active=%b lane0=%0d)", bad, bus.voice_active, lane(0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ev_valid = 1'b0;
    bus.ev_on = 1'b0;
    bus.ev_freq = '0;
    test_reset();
    test_two_notes();
    test_full_bank();
    test_release_reuse();
    test_retrigger_zero();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
